// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter
// Brief    : Round-robin sharing of one combinational logic unit between two
//            valid/ready requesters, with tagged, registered results.
// Revision : 1.0
// ============================================================================
module logic_unit_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic             lu_s1,
    output logic             lu_s0,
    input  logic [WIDTH-1:0] lu_g,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_g,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic             w_grant_id;
    logic             w_accept;
    logic             w_rsp_done;
    logic [WIDTH-1:0] r_lu_a;
    logic [WIDTH-1:0] r_lu_b;
    logic [1:0]       r_lu_op;
    logic             r_res_valid;
    logic             r_res_id;
    logic [WIDTH-1:0] r_res_g;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // On a tie the requester that was not served last wins; a lone request always wins.
    always_comb begin
        w_grant_id = req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last;
        end
    end

    // rst_n gates the accept so both readies stay low throughout reset.
    assign w_accept   = rst_n && (r_state == ST_IDLE) && (req0_valid || req1_valid);
    assign w_rsp_done = (r_state == ST_RESP) && res_ready;
    assign req0_ready = w_accept && !w_grant_id;
    assign req1_ready = w_accept &&  w_grant_id;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_state_nxt = ST_EXEC;
            ST_EXEC:                 w_state_nxt = ST_RESP;
            ST_RESP: if (res_ready)  w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= 1'b1;
            r_lu_a      <= '0;
            r_lu_b      <= '0;
            r_lu_op     <= 2'b00;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_g     <= '0;
            r_cnt0      <= '0;
            r_cnt1      <= '0;
        end else begin
            if (w_accept) begin
                r_last   <= w_grant_id;
                r_res_id <= w_grant_id;
                r_lu_a   <= w_grant_id ? req1_a  : req0_a;
                r_lu_b   <= w_grant_id ? req1_b  : req0_b;
                r_lu_op  <= w_grant_id ? req1_op : req0_op;
            end

            if (r_state == ST_EXEC) begin
                r_res_g     <= lu_g;
                r_res_valid <= 1'b1;
            end else if (w_rsp_done) begin
                r_res_valid <= 1'b0;
            end

            if (w_rsp_done) begin
                if (!r_res_id && (r_cnt0 != C_CNT_MAX)) begin
                    r_cnt0 <= r_cnt0 + C_CNT_ONE;
                end
                if (r_res_id && (r_cnt1 != C_CNT_MAX)) begin
                    r_cnt1 <= r_cnt1 + C_CNT_ONE;
                end
            end
        end
    end

    assign lu_a      = r_lu_a;
    assign lu_b      = r_lu_b;
    assign lu_s1     = r_lu_op[1];
    assign lu_s0     = r_lu_op[0];
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_g     = r_res_g;
    assign busy      = (r_state != ST_IDLE);
    assign done_cnt0 = r_cnt0;
    assign done_cnt1 = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_arbiter
// Brief    : Transaction-level reference model, directed and random stimulus.
// Revision : 1.0
// ============================================================================
module tb_logic_unit_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;
    localparam int C_CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]       req0_op = 2'b00, req1_op = 2'b00;
    logic [WIDTH-1:0] lu_a, lu_b, lu_g, res_g;
    logic             lu_s1, lu_s0;
    logic             res_valid, res_id, busy;
    logic             res_ready = 1'b1;
    logic [CNT_W-1:0] done_cnt0, done_cnt1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] g;
    } res_t;
    res_t got_q[$];

    // Reference model state: at most one outstanding operation.
    bit               m_pend = 0;
    int               m_age = 0;
    bit               m_id = 0;
    bit               m_last = 1;
    logic [WIDTH-1:0] m_g = '0;
    logic [WIDTH-1:0] m_lu_a = '0, m_lu_b = '0;
    logic [1:0]       m_lu_op = 2'b00;
    int               m_cnt0 = 0, m_cnt1 = 0;
    bit               acc0 = 0, acc1 = 0;

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] lu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign lu_g = lu_fn(lu_a, lu_b, {lu_s1, lu_s0});

    logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .lu_a(lu_a), .lu_b(lu_b), .lu_s1(lu_s1), .lu_s0(lu_s0), .lu_g(lu_g),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_g(res_g),
        .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit e_r0, e_r1, e_rv;
        if (!rst_n) begin
            chk("rst_ready0", 32'(req0_ready), 0);
            chk("rst_ready1", 32'(req1_ready), 0);
            chk("rst_lu_a", lu_a, 0);
            chk("rst_lu_b", lu_b, 0);
            chk("rst_lu_op", 32'({lu_s1, lu_s0}), 0);
            chk("rst_res_valid", 32'(res_valid), 0);
            chk("rst_res_id", 32'(res_id), 0);
            chk("rst_res_g", res_g, 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_cnt0", 32'(done_cnt0), 0);
            chk("rst_cnt1", 32'(done_cnt1), 0);
            m_pend = 0; m_age = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
            m_lu_a = '0; m_lu_b = '0; m_lu_op = 2'b00;
            acc0 = 0; acc1 = 0;
        end else begin
            e_r0 = !m_pend && req0_valid && (!req1_valid || m_last);
            e_r1 = !m_pend && req1_valid && (!req0_valid || !m_last);
            e_rv = m_pend && (m_age >= 2);
            chk("req0_ready", 32'(req0_ready), 32'(e_r0));
            chk("req1_ready", 32'(req1_ready), 32'(e_r1));
            chk("res_valid", 32'(res_valid), 32'(e_rv));
            chk("busy", 32'(busy), 32'(m_pend));
            chk("lu_a", lu_a, m_lu_a);
            chk("lu_b", lu_b, m_lu_b);
            chk("lu_op", 32'({lu_s1, lu_s0}), 32'(m_lu_op));
            chk("done_cnt0", 32'(done_cnt0), m_cnt0);
            chk("done_cnt1", 32'(done_cnt1), m_cnt1);
            if (e_rv) begin
                chk("res_id", 32'(res_id), 32'(m_id));
                chk("res_g", res_g, m_g);
            end
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (res_valid && res_ready) got_q.push_back({res_id, res_g});

            if (m_pend) begin
                if (e_rv && res_ready) begin
                    m_pend = 0;
                    if (m_id) m_cnt1 = (m_cnt1 == C_CNT_MAX) ? C_CNT_MAX : m_cnt1 + 1;
                    else      m_cnt0 = (m_cnt0 == C_CNT_MAX) ? C_CNT_MAX : m_cnt0 + 1;
                end else if (m_age < 2) begin
                    m_age++;
                end
            end else if (e_r0 || e_r1) begin
                m_pend  = 1;
                m_age   = 1;
                m_id    = e_r1;
                m_last  = e_r1;
                m_lu_a  = e_r1 ? req1_a  : req0_a;
                m_lu_b  = e_r1 ? req1_b  : req0_b;
                m_lu_op = e_r1 ? req1_op : req0_op;
                m_g     = lu_fn(m_lu_a, m_lu_b, m_lu_op);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Runs until every raised request has been accepted and its result delivered.
    task automatic settle();
        int n = 0;
        while ((req0_valid || req1_valid || m_pend) && n < 200) begin
            @(posedge clk); #1;
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL settle_timeout: actual=%0d cycles required<200", n);
        end
    endtask

    task automatic issue0(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        settle();
    endtask

    initial begin
        int n1;
        #100000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ops_exp [4];
        int n1;
        ops_exp[0] = 32'h00000000; ops_exp[1] = 32'hFFFFFFFF;
        ops_exp[2] = 32'hFFFFFFFF; ops_exp[3] = 32'h5A5A5A5A;

        // Each opcode from requester 0.
        do_reset();
        got_q.delete();
        for (int k = 0; k < 4; k++) issue0(32'hA5A5A5A5, 32'h5A5A5A5A, 2'(k));
        chk("ops_count", got_q.size(), 4);
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            chk("ops_g", got_q[k].g, ops_exp[k]);
            chk("ops_id", 32'(got_q[k].id), 0);
        end

        // Tie from reset: requester 0 first, then 1.
        do_reset();
        got_q.delete();
        req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F; req0_op = 2'b00; req0_valid = 1'b1;
        req1_a = 32'h12345678; req1_b = 32'hFFFFFFFF; req1_op = 2'b10; req1_valid = 1'b1;
        settle();
        chk("tie_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("tie_first", {31'(got_q[0].id), 1'b0} ^ got_q[0].g, {31'd0, 1'b0} ^ 32'h0F0F0000);
            chk("tie_first_id", 32'(got_q[0].id), 0);
            chk("tie_second_id", 32'(got_q[1].id), 1);
            chk("tie_second_g", got_q[1].g, 32'hEDCBA987);
        end

        // Backpressure in RESP.
        do_reset();
        res_ready = 1'b0;
        req0_a = 32'hF0F0F0F0; req0_b = 32'h0000FFFF; req0_op = 2'b01; req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_a = 32'h0000FFFF; req1_b = 32'h0; req1_op = 2'b11; req1_valid = 1'b1;
        @(posedge clk); #1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_res_valid", 32'(res_valid), 1);
            chk("bp_res_g", res_g, 32'hF0F0FFFF);
            chk("bp_ready", 32'({req0_ready, req1_ready}), 0);
            chk("bp_busy", 32'(busy), 1);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_cnt0", 32'(done_cnt0), 1);
        chk("bp_cnt1", 32'(done_cnt1), 0);
        settle();
        chk("bp_cnt1_after", 32'(done_cnt1), 1);

        // Reset while an operation is executing.
        do_reset();
        got_q.delete();
        req0_a = 32'h11111111; req0_b = 32'h22222222; req0_op = 2'b01; req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_a = 32'hCAFEF00D; req0_b = 32'hFFFF0000; req0_op = 2'b00;
        req1_a = 32'h0F0F0F0F; req1_b = 32'h00000000; req1_op = 2'b11; req1_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_lu_a", lu_a, 0);
        chk("arst_ready", 32'({req0_ready, req1_ready}), 0);
        chk("arst_res_valid", 32'(res_valid), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        settle();
        chk("arst_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("arst_first_id", 32'(got_q[0].id), 0);
            chk("arst_first_g", got_q[0].g, 32'hCAFE0000);
            chk("arst_second_g", got_q[1].g, 32'hF0F0F0F0);
        end

        // Lone requester 1, many times: always granted, counter saturates.
        do_reset();
        got_q.delete();
        for (int k = 0; k < 260; k++) begin
            req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom_range(0, 3));
            req1_valid = 1'b1;
            settle();
        end
        n1 = 0;
        foreach (got_q[k]) if (got_q[k].id) n1++;
        chk("solo1_grants", n1, 260);
        chk("sat_cnt1", 32'(done_cnt1), 32'hFF);
        chk("sat_cnt0", 32'(done_cnt0), 0);

        // Random traffic with random backpressure.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #1;
            if (!req0_valid || acc0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom_range(0, 3));
            end
            if (!req1_valid || acc1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom_range(0, 3));
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        res_ready = 1'b1;
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one combinational 32-bit logic unit (AND/OR/XOR/NOT selected by S1/S0) between two requesters. Each requester issues an operation through a valid/ready handshake. The arbiter grants one request at a time in round-robin order and drives the logic unit's A/B/S1/S0 inputs from registers. It captures G and returns the result with a requester tag under a valid/ready handshake. It sits between the function-unit control path and the `logic_unit` instance.

## Interface
- `WIDTH`, 32, operand and result width
- `CNT_W`, 8, width of the per-requester completion counters
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req0_valid` in 1: requester 0 has an operation pending
- `req0_ready` out 1: requester 0 operation accepted this cycle
- `req0_a`, `req0_b` in WIDTH: requester 0 operands
- `req0_op` in 2: requester 0 opcode; 00 AND, 01 OR, 10 XOR, 11 NOT A
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1
- `lu_a`, `lu_b` out WIDTH: registered operands to the logic unit
- `lu_s1`, `lu_s0` out 1: registered select to the logic unit; `lu_s1`=op[1], `lu_s0`=op[0]
- `lu_g` in WIDTH: logic unit result (combinational)
- `res_valid` out 1: result available
- `res_ready` in 1: consumer accepts the result
- `res_id` out 1: requester that owns the result
- `res_g` out WIDTH: registered result
- `busy` out 1: state is not IDLE
- `done_cnt0`, `done_cnt1` out CNT_W: saturating count of results delivered per requester

## Operation
- State machine:
  - IDLE: if any `reqN_valid`, assert `reqN_ready` for the granted requester. Capture `a`, `b` and `op` into `lu_*`, and its id into `res_id`. Go to EXEC. Otherwise stay in IDLE.
  - EXEC: `lu_*` stable; capture `lu_g` into `res_g`; go to RESP.
  - RESP: `res_valid`=1. On `res_ready`=1, increment the owning `done_cntN` (saturating at all-ones) and go to IDLE. Otherwise hold.
- Arbitration:
  - `last` register holds the id of the most recent grant.
  - Only one valid request: grant it.
  - Both valid: grant `~last`.
  - `last` updates only on accept.
  - Reset value of `last` = 1, so requester 0 wins the first tie.
- `req0_ready`/`req1_ready` are combinational from state, the valids and `last`. They are never both high, and they are 0 outside IDLE.
- A requester must hold `valid`, `a`, `b` and `op` until ready; a deasserted valid is simply not granted.
- `lu_*` keep their last value in IDLE and RESP; they are not cleared between operations.
- Reset (async, any state): state=IDLE, `last`=1, `lu_a`=`lu_b`=0, `lu_s1`=`lu_s0`=0, `res_valid`=0, `res_id`=0, `res_g`=0, counters=0, both ready=0.
  - While `rst_n` is low, both ready are held at 0.
  - An in-flight operation is dropped and produces no result.

## Timing
- Accept at edge N (IDLE→EXEC); `lu_*` valid after N; `res_g` captured at N+1; `res_valid` high from N+1.
- Accept-to-`res_valid` latency: 2 cycles.
- Minimum issue interval: 3 cycles (IDLE, EXEC, RESP), with `res_ready` tied high.
- `res_valid`, `res_id` and `res_g` are stable while `res_valid`=1 and `res_ready`=0.
- The result handshake completes on the edge where `res_valid`=1 and `res_ready`=1. The next accept happens no earlier than the following edge.
- Round-robin with both valid continuously gives grant order 0,1,0,1,…

## Test plan
- Req0 with A=A5A5A5A5, B=5A5A5A5A, ops 00/01/10/11 in turn, `res_ready`=1 -> `res_g` = 00000000, FFFFFFFF, FFFFFFFF, 5A5A5A5A; `res_id`=0; `res_valid` 2 cycles after each accept.
- Both valid from reset: req0 A=FFFF0000, B=0F0F0F0F, op=00; req1 A=12345678, B=FFFFFFFF, op=10 -> first result id=0 g=0F0F0000, second result id=1 g=EDCBA987.
- Backpressure: `res_ready`=0 for 5 cycles in RESP -> `res_valid`/`res_g` held, both ready=0, `busy`=1. Then `res_ready`=1 -> exactly one `done_cnt` increment.
- Reset pulse during EXEC -> all outputs at reset values immediately. After release, no result is delivered for the dropped op, and the first tie goes to req0.
- Saturation, CNT_W=8: deliver 260 req1 results -> `done_cnt1`=FF, `done_cnt0`=0.
- Only req1 valid, repeatedly -> req1 is granted every time despite `last`=1.
